// File: rtl/palette_pkg.sv
// Shared types and helpers for the palette RAM port arbiter.
// The palette word address is {layer, colour, word_sel}.
package palette_pkg;

  localparam int LAYER_W    = 5;
  localparam int COLOR_W    = 5;
  localparam int PAL_ADDR_W = LAYER_W + COLOR_W + 1;

  localparam logic WORD_GB    = 1'b0;
  localparam logic WORD_R     = 1'b1;
  localparam int   OPAQUE_BIT = 15;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    CW   = 3'd3,
    CR   = 3'd4
  } state_t;

  function automatic logic [PAL_ADDR_W-1:0] pack_addr(
    input logic [LAYER_W-1:0] layer,
    input logic [COLOR_W-1:0] color,
    input logic               word_sel
  );
    return {layer, color, word_sel};
  endfunction

endpackage

// File: rtl/palette_port_arbiter_if.sv
// Bundle of the pipeline lookup port, the controller access port and the
// palette RAM port. The arbiter uses the slave modport, its environment the master.
//
// Handshakes:
//   pipeline   : a lookup is accepted in any cycle where pipe_req & pipe_ready;
//                its result arrives as a one-cycle pipe_valid four cycles later.
//   controller : ctrl_req and all ctrl_* qualifiers are held stable until the
//                one-cycle ctrl_ack; ctrl_rdata is valid with ctrl_ack on reads.
//   memory     : mem_en issues an access; read data is on mem_rdata next cycle.
interface palette_port_arbiter_if #(
  parameter int ADDR_W = 11
);
  import palette_pkg::*;

  logic               pipe_req;
  logic               pipe_ready;
  logic [LAYER_W-1:0] pipe_layer;
  logic [COLOR_W-1:0] pipe_color;
  logic               pipe_valid;
  logic [23:0]        pipe_rgb;
  logic               pipe_opaque;

  logic               ctrl_req;
  logic               ctrl_we;
  logic [LAYER_W-1:0] ctrl_layer;
  logic [COLOR_W-1:0] ctrl_color;
  logic               ctrl_rgb_sel;
  logic [15:0]        ctrl_wdata;
  logic               ctrl_ack;
  logic [15:0]        ctrl_rdata;

  logic               mem_en;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [15:0]        mem_wdata;
  logic [15:0]        mem_rdata;

  modport slave (
    input  pipe_req, pipe_layer, pipe_color,
    input  ctrl_req, ctrl_we, ctrl_layer, ctrl_color, ctrl_rgb_sel, ctrl_wdata,
    input  mem_rdata,
    output pipe_ready, pipe_valid, pipe_rgb, pipe_opaque,
    output ctrl_ack, ctrl_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output pipe_req, pipe_layer, pipe_color,
    output ctrl_req, ctrl_we, ctrl_layer, ctrl_color, ctrl_rgb_sel, ctrl_wdata,
    output mem_rdata,
    input  pipe_ready, pipe_valid, pipe_rgb, pipe_opaque,
    input  ctrl_ack, ctrl_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/palette_starve_counter.sv
// Saturating wait counter for the controller; at_limit forces the next
// grant to the controller.
module palette_starve_counter #(
  parameter int LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         inc,
  output logic [$clog2(LIMIT+1)-1:0]   count,
  output logic                         at_limit
);

  localparam int W = $clog2(LIMIT + 1);

  assign at_limit = (count == W'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/palette_port_arbiter.sv
// Single-port palette RAM arbiter: pipeline lookups (two reads assembled into
// RGB888 + opaque) have priority; a starvation guard lets controller accesses in.
module palette_port_arbiter
  import palette_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = 11
) (
  input  logic                                clk_pipe,
  input  logic                                rst,
  palette_port_arbiter_if.slave               bus,
  output state_t                              dbg_state,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]   dbg_starve
);

  state_t             state, next_state;
  logic [LAYER_W-1:0] lk_layer;
  logic [COLOR_W-1:0] lk_color;
  logic [15:0]        word0;
  logic               word1_due;
  logic [15:0]        rdata_q;
  logic               grant_pipe;
  logic               starve_at_limit;
  logic               starve_hit;
  logic               starve_inc;
  logic               starve_clear;

  assign starve_hit   = bus.ctrl_req & starve_at_limit;
  assign starve_inc   = bus.ctrl_req & (state != CW) & (state != CR);
  assign starve_clear = ~bus.ctrl_req | (next_state == CW);

  palette_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk_pipe),
    .rst      (rst),
    .clear    (starve_clear),
    .inc      (starve_inc),
    .count    (dbg_starve),
    .at_limit (starve_at_limit)
  );

  always_ff @(posedge clk_pipe) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state     = state;
    grant_pipe     = 1'b0;
    bus.pipe_ready = 1'b0;
    bus.ctrl_ack   = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state)
      IDLE, P1: begin
        // Grant point: starved controller, then pipeline, then controller.
        bus.pipe_ready = ~starve_hit;
        if (starve_hit) begin
          next_state = CW;
        end else if (bus.pipe_req) begin
          next_state = P0;
          grant_pipe = 1'b1;
        end else if (bus.ctrl_req) begin
          next_state = CW;
        end else begin
          next_state = IDLE;
        end
        if (state == P1) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = ADDR_W'(pack_addr(lk_layer, lk_color, WORD_R));
        end
      end
      P0: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = ADDR_W'(pack_addr(lk_layer, lk_color, WORD_GB));
        next_state   = P1;
      end
      CW: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.ctrl_we;
        bus.mem_addr  = ADDR_W'(pack_addr(bus.ctrl_layer, bus.ctrl_color, bus.ctrl_rgb_sel));
        bus.mem_wdata = bus.ctrl_we ? bus.ctrl_wdata : 16'h0000;
        bus.ctrl_ack  = bus.ctrl_we;
        next_state    = bus.ctrl_we ? IDLE : CR;
      end
      CR: begin
        bus.ctrl_ack = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Read data for the controller is forwarded in CR and held afterwards.
  assign bus.ctrl_rdata = (state == CR) ? bus.mem_rdata : rdata_q;
  assign dbg_state      = state;

  always_ff @(posedge clk_pipe) begin
    if (rst) begin
      lk_layer        <= '0;
      lk_color        <= '0;
      word0           <= '0;
      word1_due       <= 1'b0;
      rdata_q         <= '0;
      bus.pipe_valid  <= 1'b0;
      bus.pipe_rgb    <= '0;
      bus.pipe_opaque <= 1'b0;
    end else begin
      if (grant_pipe) begin
        lk_layer <= bus.pipe_layer;
        lk_color <= bus.pipe_color;
      end
      if (state == P1) word0 <= bus.mem_rdata;
      if (state == CR) rdata_q <= bus.mem_rdata;
      word1_due      <= (state == P1);
      bus.pipe_valid <= word1_due;
      if (word1_due) begin
        bus.pipe_rgb    <= {bus.mem_rdata[7:0], word0};
        bus.pipe_opaque <= bus.mem_rdata[OPAQUE_BIT];
      end
    end
  end

endmodule

// File: tb/tb_palette_port_arbiter.sv
// Bench for palette_port_arbiter: directed scenarios followed by random
// traffic, checked against a palette image and a lookup result queue.
module tb_palette_port_arbiter;
  import palette_pkg::*;

  localparam int LIMIT = 8;

  logic clk_pipe = 1'b0;
  logic rst      = 1'b1;
  always #5 clk_pipe = ~clk_pipe;

  palette_port_arbiter_if #(.ADDR_W(11)) bus ();
  state_t     dbg_state;
  logic [3:0] dbg_starve;

  palette_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(11)) dut (
    .clk_pipe   (clk_pipe),
    .rst        (rst),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_starve (dbg_starve)
  );

  // Palette macro model (one-cycle read latency) with a preload port.
  logic [15:0] ram [2048];
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr;
  logic [15:0] pre_data;
  always @(posedge clk_pipe) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // Reference palette image and expected lookup results.
  logic [15:0] gold [2048];
  logic [24:0] exp_q[$];
  int          due_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  int          waited = 0;
  bit          last_ack, last_accept;

  function automatic int addr_of(input int l, input int c, input int s);
    return l * 64 + c * 2 + s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = 11'(a); pre_data = d; gold[a] = d;
    @(posedge clk_pipe); #1;
    pre_we = 1'b0;
  endtask

  // Scoreboard work done at every sample point.
  task automatic monitor();
    int a;
    logic [24:0] e;
    int d;
    last_ack = 1'b0; last_accept = 1'b0;
    if (bus.pipe_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 32'(bus.pipe_valid), 32'd0);
      else begin
        e = exp_q.pop_front(); d = due_q.pop_front();
        chk("pipe_rgb", 32'(bus.pipe_rgb), 32'(e[23:0]));
        chk("pipe_opaque", 32'(bus.pipe_opaque), 32'(e[24]));
        chk("pipe_latency", cycle, d);
      end
    end else if (due_q.size() != 0 && due_q[0] <= cycle) begin
      chk("missing_valid", 32'(bus.pipe_valid), 32'd1);
      void'(exp_q.pop_front()); void'(due_q.pop_front());
    end
    if (bus.ctrl_ack) begin
      last_ack = 1'b1;
      a = addr_of(int'(bus.ctrl_layer), int'(bus.ctrl_color), int'(bus.ctrl_rgb_sel));
      if (bus.ctrl_we) gold[a] = bus.ctrl_wdata;
      else chk("ctrl_rdata", 32'(bus.ctrl_rdata), 32'(gold[a]));
      chk("ctrl_wait_bound", 32'(waited <= LIMIT + 3), 32'd1);
    end
    if (rst) begin
      exp_q.delete(); due_q.delete();
    end else if (bus.pipe_req && bus.pipe_ready) begin
      last_accept = 1'b1;
      a = addr_of(int'(bus.pipe_layer), int'(bus.pipe_color), 0);
      exp_q.push_back({gold[a+1][15], gold[a+1][7:0], gold[a]});
      due_q.push_back(cycle + 4);
    end
  endtask

  task automatic settle();
    @(negedge clk_pipe);
    monitor();
  endtask

  task automatic advance();
    if (bus.ctrl_req) waited++;
    @(posedge clk_pipe); #1;
    cycle++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int acc;
    bus.pipe_req = 0; bus.pipe_layer = 0; bus.pipe_color = 0;
    bus.ctrl_req = 0; bus.ctrl_we = 0; bus.ctrl_layer = 0; bus.ctrl_color = 0;
    bus.ctrl_rgb_sel = 0; bus.ctrl_wdata = 0;

    // Preload the palette while the arbiter is held in reset.
    rst = 1'b1;
    for (int i = 0; i < 2048; i++) preload(i, 16'($urandom));
    preload(addr_of(3, 7, 0), 16'h5566);
    preload(addr_of(3, 7, 1), 16'h8011);

    settle();
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_ready", 32'(bus.pipe_ready), 32'd1);
    chk("rst_valid", 32'(bus.pipe_valid), 32'd0);
    chk("rst_ack", 32'(bus.ctrl_ack), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_rgb", 32'(bus.pipe_rgb), 32'd0);
    advance();
    rst = 1'b0;

    // Single lookup of layer 3, colour 7.
    bus.pipe_req = 1; bus.pipe_layer = 5'd3; bus.pipe_color = 5'd7;
    settle(); chk("t1_ready", 32'(bus.pipe_ready), 32'd1); advance();
    bus.pipe_req = 0;
    settle();
    chk("t1_p0_en", 32'(bus.mem_en), 32'd1);
    chk("t1_p0_addr", 32'(bus.mem_addr), 32'(addr_of(3, 7, 0)));
    chk("t1_p0_ready", 32'(bus.pipe_ready), 32'd0);
    advance();
    settle(); chk("t1_p1_addr", 32'(bus.mem_addr), 32'(addr_of(3, 7, 1))); advance();
    settle(); chk("t1_early_valid", 32'(bus.pipe_valid), 32'd0); advance();
    settle();
    chk("t1_valid", 32'(bus.pipe_valid), 32'd1);
    chk("t1_rgb", 32'(bus.pipe_rgb), 32'h115566);
    chk("t1_opaque", 32'(bus.pipe_opaque), 32'd1);
    advance();
    settle();
    chk("t1_valid_pulse", 32'(bus.pipe_valid), 32'd0);
    chk("t1_rgb_hold", 32'(bus.pipe_rgb), 32'h115566);
    advance();

    // Controller write of 16'hABCD to {1,2,0}, then read it back.
    bus.ctrl_req = 1; bus.ctrl_we = 1; bus.ctrl_layer = 5'd1; bus.ctrl_color = 5'd2;
    bus.ctrl_rgb_sel = 0; bus.ctrl_wdata = 16'hABCD; waited = 0;
    settle(); chk("t2_grant_ack", 32'(bus.ctrl_ack), 32'd0); advance();
    settle();
    chk("t2_w_ack", 32'(bus.ctrl_ack), 32'd1);
    chk("t2_w_en", 32'(bus.mem_en), 32'd1);
    chk("t2_w_we", 32'(bus.mem_we), 32'd1);
    chk("t2_w_addr", 32'(bus.mem_addr), 32'h044);
    chk("t2_w_data", 32'(bus.mem_wdata), 32'hABCD);
    advance();
    bus.ctrl_req = 0; bus.ctrl_we = 0;
    settle(); chk("t2_ack_pulse", 32'(bus.ctrl_ack), 32'd0); advance();
    bus.ctrl_req = 1; waited = 0;
    settle(); advance();
    settle();
    chk("t2_r_state", 32'(dbg_state), 32'(CW));
    chk("t2_r_we", 32'(bus.mem_we), 32'd0);
    chk("t2_r_early_ack", 32'(bus.ctrl_ack), 32'd0);
    advance();
    settle();
    chk("t2_r_ack", 32'(bus.ctrl_ack), 32'd1);
    chk("t2_r_data", 32'(bus.ctrl_rdata), 32'hABCD);
    advance();
    bus.ctrl_req = 0;
    settle(); advance();

    // Three back-to-back lookups.
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      bus.pipe_req = (acc < 3);
      bus.pipe_layer = 5'(10 + acc); bus.pipe_color = 5'(3 * acc + 1);
      settle();
      chk("t4_ready", 32'(bus.pipe_ready), (k == 1 || k == 3 || k == 5) ? 32'd0 : 32'd1);
      chk("t4_valid", 32'(bus.pipe_valid), (k == 4 || k == 6 || k == 8) ? 32'd1 : 32'd0);
      chk("t4_no_ack", 32'(bus.ctrl_ack), 32'd0);
      if (bus.pipe_req && bus.pipe_ready) acc++;
      advance();
    end
    bus.pipe_req = 0;

    // Reset asserted while the lookup is in P1.
    bus.pipe_req = 1; bus.pipe_layer = 5'd5; bus.pipe_color = 5'd9;
    settle(); advance();
    bus.pipe_req = 0;
    settle(); advance();
    settle(); chk("t5_in_p1", 32'(dbg_state), 32'(P1));
    rst = 1'b1; advance();
    settle();
    chk("t5_state", 32'(dbg_state), 32'(IDLE));
    chk("t5_mem_en", 32'(bus.mem_en), 32'd0);
    chk("t5_rgb", 32'(bus.pipe_rgb), 32'd0);
    chk("t5_valid", 32'(bus.pipe_valid), 32'd0);
    rst = 1'b0; advance();
    settle();
    chk("t5_ready_after", 32'(bus.pipe_ready), 32'd1);
    chk("t5_no_valid", 32'(bus.pipe_valid), 32'd0);
    advance();
    settle(); chk("t5_no_valid2", 32'(bus.pipe_valid), 32'd0); advance();

    // Both requesters start together: pipeline first, controller after P1.
    bus.pipe_req = 1; bus.pipe_layer = 5'd2; bus.pipe_color = 5'd3;
    bus.ctrl_req = 1; bus.ctrl_we = 0; bus.ctrl_layer = 5'd1; bus.ctrl_color = 5'd2;
    bus.ctrl_rgb_sel = 0; waited = 0;
    settle(); chk("t6_ready", 32'(bus.pipe_ready), 32'd1); chk("t6_cnt0", 32'(dbg_starve), 32'd0); advance();
    bus.pipe_req = 0;
    settle(); chk("t6_p0", 32'(dbg_state), 32'(P0)); chk("t6_cnt1", 32'(dbg_starve), 32'd1); advance();
    settle(); chk("t6_p1", 32'(dbg_state), 32'(P1)); chk("t6_cnt2", 32'(dbg_starve), 32'd2); advance();
    settle();
    chk("t6_cw", 32'(dbg_state), 32'(CW));
    chk("t6_addr", 32'(bus.mem_addr), 32'h044);
    chk("t6_cnt_clr", 32'(dbg_starve), 32'd0);
    advance();
    settle(); chk("t6_ack", 32'(bus.ctrl_ack), 32'd1); chk("t6_rdata", 32'(bus.ctrl_rdata), 32'hABCD); advance();
    bus.ctrl_req = 0;
    settle(); advance();

    // Pipeline streams continuously while the controller waits.
    bus.pipe_req = 1; bus.pipe_layer = 5'($urandom_range(0, 31)); bus.pipe_color = 5'($urandom_range(0, 31));
    settle(); advance();
    bus.ctrl_req = 1; bus.ctrl_we = 0; bus.ctrl_layer = 5'd7; bus.ctrl_color = 5'd9;
    bus.ctrl_rgb_sel = 1; waited = 0; done = 0;
    for (int k = 0; k < 24 && !done; k++) begin
      if (last_accept) begin
        bus.pipe_layer = 5'($urandom_range(0, 31)); bus.pipe_color = 5'($urandom_range(0, 31));
      end
      settle();
      if (waited <= LIMIT) chk("t3_starve_cnt", 32'(dbg_starve), 32'(waited));
      if (waited >= LIMIT) chk("t3_ready_held", 32'(bus.pipe_ready), 32'd0);
      if (bus.ctrl_ack) done = 1;
      advance();
    end
    chk("t3_ack_seen", 32'(done), 32'd1);
    bus.ctrl_req = 0;
    settle(); chk("t3_ready_back", 32'(bus.pipe_ready), 32'd1); advance();
    bus.pipe_req = 0;
    for (int k = 0; k < 6; k++) begin settle(); advance(); end

    // Random traffic over a small address window.
    for (int k = 0; k < 400; k++) begin
      if (!bus.pipe_req || last_accept) begin
        bus.pipe_req   = ($urandom_range(0, 3) != 0);
        bus.pipe_layer = 5'($urandom_range(0, 3));
        bus.pipe_color = 5'($urandom_range(0, 3));
      end
      if (bus.ctrl_req && last_ack) begin
        bus.ctrl_req = 0;
      end else if (!bus.ctrl_req && $urandom_range(0, 4) == 0) begin
        bus.ctrl_req     = 1;
        bus.ctrl_we      = 1'($urandom_range(0, 1));
        bus.ctrl_layer   = 5'($urandom_range(0, 3));
        bus.ctrl_color   = 5'($urandom_range(0, 3));
        bus.ctrl_rgb_sel = 1'($urandom_range(0, 1));
        bus.ctrl_wdata   = 16'($urandom);
        waited = 0;
      end
      settle(); advance();
    end
    bus.pipe_req = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.ctrl_req && last_ack) bus.ctrl_req = 0;
      settle(); advance();
    end
    chk("drain_lookups", 32'(exp_q.size()), 32'd0);
    chk("drain_ctrl_done", 32'(bus.ctrl_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
